// File: rtl/ghost_typist.sv
// ghost_typist: replays a dictionary word as timed keyboard press/release
// events, with optional per-letter mistype-and-correct injection.
module ghost_typist #(
  parameter int HOLD = 2,
  parameter int GAP  = 3
) (
  input  logic         clk_div,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [74:0]  word,
  input  logic [4:0]   wordnum,
  input  logic         inject_err,
  output logic [127:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid,
  output logic         busy,
  output logic         done,
  output logic [4:0]   sent_cnt,
  output logic [4:0]   err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESS, S_HOLD, S_REL, S_GAP, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_LET, K_WRONG, K_BACK, K_SPACE
  } kind_t;

  localparam logic [6:0] SC_BACK  = 7'd102;
  localparam logic [6:0] SC_SPACE = 7'd41;
  localparam logic [3:0] HOLD_END = 4'(HOLD - 1);
  localparam logic [3:0] GAP_END  = 4'(GAP - 1);

  function automatic logic [6:0] scan(input logic [4:0] c);
    logic [6:0] s;
    case (c)
      5'd1:  s = 7'd28;  5'd2:  s = 7'd50;  5'd3:  s = 7'd33;
      5'd4:  s = 7'd35;  5'd5:  s = 7'd36;  5'd6:  s = 7'd43;
      5'd7:  s = 7'd52;  5'd8:  s = 7'd51;  5'd9:  s = 7'd67;
      5'd10: s = 7'd59;  5'd11: s = 7'd66;  5'd12: s = 7'd75;
      5'd13: s = 7'd58;  5'd14: s = 7'd49;  5'd15: s = 7'd68;
      5'd16: s = 7'd77;  5'd17: s = 7'd21;  5'd18: s = 7'd45;
      5'd19: s = 7'd27;  5'd20: s = 7'd44;  5'd21: s = 7'd60;
      5'd22: s = 7'd42;  5'd23: s = 7'd29;  5'd24: s = 7'd34;
      5'd25: s = 7'd53;  5'd26: s = 7'd26;
      default: s = 7'd0;
    endcase
    return s;
  endfunction

  state_t       state, state_n;
  kind_t        kind, kind_n, f_kind;
  logic [74:0]  word_q, word_q_n;
  logic [3:0]   wlen, wlen_n, idx, idx_n, cnt, cnt_n;
  logic [4:0]   code, code_n;
  logic [6:0]   sc, sc_n, f_sc;
  logic         fin, fin_n;
  logic [127:0] key_down_n;
  logic [8:0]   last_change_n;
  logic         key_valid_n, busy_n, done_n;
  logic [4:0]   sent_n, err_n;

  logic [79:0]  f_src;
  logic [3:0]   f_len, f_idx, clamp;
  logic [4:0]   f_code, f_wrap;

  assign clamp = (wordnum > 5'd15) ? 4'd15 : wordnum[3:0];

  // Next key after the current one: letter 0 when idle, else letter idx+1
  always_comb begin
    f_src  = (state == S_IDLE) ? {5'd0, word} : {5'd0, word_q};
    f_len  = (state == S_IDLE) ? clamp : wlen;
    f_idx  = (state == S_IDLE) ? 4'd0 : idx + 4'd1;
    f_code = f_src[7'(f_idx) * 7'd5 +: 5];
    f_wrap = (f_code == 5'd26) ? 5'd1 : f_code + 5'd1;
    f_kind = K_SPACE;
    f_sc   = SC_SPACE;
    if (f_idx < f_len && f_code != 5'd0 && f_code <= 5'd26) begin
      if (inject_err) begin
        f_kind = K_WRONG;
        f_sc   = scan(f_wrap);
      end else begin
        f_kind = K_LET;
        f_sc   = scan(f_code);
      end
    end
  end

  always_comb begin
    state_n       = state;
    kind_n        = kind;
    word_q_n      = word_q;
    wlen_n        = wlen;
    idx_n         = idx;
    cnt_n         = cnt;
    code_n        = code;
    sc_n          = sc;
    fin_n         = fin;
    key_down_n    = key_down;
    last_change_n = last_change;
    key_valid_n   = 1'b0;
    busy_n        = busy;
    done_n        = 1'b0;
    sent_n        = sent_cnt;
    err_n         = err_cnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          word_q_n = word;
          wlen_n   = clamp;
          idx_n    = 4'd0;
          sent_n   = 5'd0;
          err_n    = 5'd0;
          fin_n    = 1'b0;
          busy_n   = 1'b1;
          kind_n   = f_kind;
          sc_n     = f_sc;
          code_n   = f_code;
          state_n  = (clamp == 4'd0) ? S_DONE : S_PRESS;
        end
      end
      S_PRESS: begin
        key_down_n    = 128'(1) << sc;
        last_change_n = {2'b00, sc};
        key_valid_n   = 1'b1;
        if (kind == K_WRONG && err_cnt != 5'd31)
          err_n = err_cnt + 5'd1;
        cnt_n   = 4'd0;
        state_n = S_HOLD;
      end
      S_HOLD: begin
        if (cnt == HOLD_END) state_n = S_REL;
        else cnt_n = cnt + 4'd1;
      end
      S_REL: begin
        key_down_n    = '0;
        last_change_n = {2'b00, sc};
        key_valid_n   = 1'b1;
        cnt_n         = 4'd0;
        unique case (kind)
          K_WRONG: begin
            kind_n = K_BACK;
            sc_n   = SC_BACK;
          end
          K_BACK: begin
            kind_n = K_LET;
            sc_n   = scan(code);
          end
          K_LET: begin
            sent_n = sent_cnt + 5'd1;
            idx_n  = idx + 4'd1;
            kind_n = f_kind;
            sc_n   = f_sc;
            code_n = f_code;
          end
          default: fin_n = 1'b1;
        endcase
        if (GAP == 0) state_n = fin_n ? S_DONE : S_PRESS;
        else state_n = S_GAP;
      end
      S_GAP: begin
        if (cnt == GAP_END) state_n = fin ? S_DONE : S_PRESS;
        else cnt_n = cnt + 4'd1;
      end
      S_DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Cancel wins over everything, including a same-cycle start
    if (abort) begin
      state_n     = S_IDLE;
      key_down_n  = '0;
      key_valid_n = 1'b0;
      busy_n      = 1'b0;
      done_n      = 1'b0;
      sent_n      = sent_cnt;
      err_n       = err_cnt;
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      kind        <= K_LET;
      word_q      <= '0;
      wlen        <= '0;
      idx         <= '0;
      cnt         <= '0;
      code        <= '0;
      sc          <= '0;
      fin         <= 1'b0;
      key_down    <= '0;
      last_change <= '0;
      key_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sent_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_n;
      kind        <= kind_n;
      word_q      <= word_q_n;
      wlen        <= wlen_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      code        <= code_n;
      sc          <= sc_n;
      fin         <= fin_n;
      key_down    <= key_down_n;
      last_change <= last_change_n;
      key_valid   <= key_valid_n;
      busy        <= busy_n;
      done        <= done_n;
      sent_cnt    <= sent_n;
      err_cnt     <= err_n;
    end
  end

endmodule

// File: tb/tb_ghost_typist.sv
// tb_ghost_typist: directed replay scenarios with an event scoreboard
// built from the scancode table and the press/hold/release/gap timing.
module tb_ghost_typist;

  logic         clk_div = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, start2 = 1'b0, abort = 1'b0;
  logic         inject_err = 1'b0;
  logic [74:0]  word = '0;
  logic [4:0]   wordnum = '0;

  logic [127:0] kd1, kd2, o_kd;
  logic [8:0]   lc1, lc2, o_lc;
  logic         kv1, kv2, o_kv, bz1, bz2, o_bz, dn1, dn2, o_dn;
  logic [4:0]   sc1, sc2, o_sc, ec1, ec2, o_ec;
  bit           sel = 1'b0;

  always #5 clk_div = ~clk_div;

  ghost_typist dut (
    .clk_div(clk_div), .rst(rst), .start(start), .abort(abort),
    .word(word), .wordnum(wordnum), .inject_err(inject_err),
    .key_down(kd1), .last_change(lc1), .key_valid(kv1),
    .busy(bz1), .done(dn1), .sent_cnt(sc1), .err_cnt(ec1)
  );

  ghost_typist #(.HOLD(1), .GAP(0)) dut2 (
    .clk_div(clk_div), .rst(rst), .start(start2), .abort(abort),
    .word(word), .wordnum(wordnum), .inject_err(inject_err),
    .key_down(kd2), .last_change(lc2), .key_valid(kv2),
    .busy(bz2), .done(dn2), .sent_cnt(sc2), .err_cnt(ec2)
  );

  always_comb begin
    o_kd = sel ? kd2 : kd1;
    o_lc = sel ? lc2 : lc1;
    o_kv = sel ? kv2 : kv1;
    o_bz = sel ? bz2 : bz1;
    o_dn = sel ? dn2 : dn1;
    o_sc = sel ? sc2 : sc1;
    o_ec = sel ? ec2 : ec1;
  end

  typedef struct {
    int t;
    int sc;
    bit press;
  } ev_t;

  ev_t q[$];
  int  checks = 0, errors = 0;
  int  x_done, x_sent, x_err;
  int  got_done, pulses;
  int  sct[27] = '{0, 28, 50, 33, 35, 36, 43, 52, 51, 67, 59, 66, 75, 58,
                   49, 68, 77, 21, 45, 27, 44, 60, 42, 29, 34, 53, 26};

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic set_word(input int c0, c1, c2, c3, input int n);
    word = '0;
    word[4:0]   = 5'(c0);
    word[9:5]   = 5'(c1);
    word[14:10] = 5'(c2);
    word[19:15] = 5'(c3);
    wordnum = 5'(n);
  endtask

  // Expected key stream and timing, pushed before the replay starts
  task automatic model(input int h, input int g);
    int keys[$];
    int n, c, t;
    logic [74:0] w;
    w = word;
    n = (wordnum > 15) ? 15 : int'(wordnum);
    x_sent = 0;
    x_err = 0;
    x_done = 1;
    q.delete();
    for (int i = 0; i < n; i++) begin
      c = int'(w[5*i +: 5]);
      if (c == 0 || c > 26) break;
      if (inject_err) begin
        keys.push_back(sct[(c == 26) ? 1 : c + 1]);
        keys.push_back(102);
        x_err++;
      end
      keys.push_back(sct[c]);
      x_sent++;
    end
    if (n > 0) keys.push_back(41);
    foreach (keys[j]) begin
      t = 1 + j * (2 + h + g);
      q.push_back('{t, keys[j], 1'b1});
      q.push_back('{t + 1 + h, keys[j], 1'b0});
      x_done = t + 2 + h + g;
    end
  endtask

  // Edge 0 is the first posedge after entry; start must already be driven
  task automatic run(input int last, input int abort_at,
                     input int restart_at);
    ev_t e;
    got_done = -1;
    pulses = 0;
    @(posedge clk_div);
    @(negedge clk_div);
    start = 1'b0;
    start2 = 1'b0;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk_div);
      @(negedge clk_div);
      chk("onehot0", 128'($countones(o_kd) <= 1), 128'(1));
      if (o_kv) begin
        pulses++;
        chk("event_expected", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("ev_edge", 128'(n), 128'(e.t));
          chk("ev_scancode", 128'(o_lc), 128'(e.sc));
          chk("ev_key_down", o_kd,
              e.press ? (128'(1) << e.sc) : 128'(0));
        end
      end
      if (o_dn) got_done = n;
      if (n == abort_at) begin
        chk("abort_kd", o_kd, 128'(0));
        chk("abort_busy", 128'(o_bz), 128'(0));
        chk("abort_kv", 128'(o_kv), 128'(0));
      end
      abort = (n == abort_at - 1);
      start = (n == restart_at);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic finish_checks(input string tag);
    chk({tag, "_done_edge"}, 128'(got_done), 128'(x_done));
    chk({tag, "_leftover"}, 128'(q.size()), 128'(0));
    chk({tag, "_sent"}, 128'(o_sc), 128'(x_sent));
    chk({tag, "_err"}, 128'(o_ec), 128'(x_err));
    chk({tag, "_busy"}, 128'(o_bz), 128'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk_div);
    chk("rst_kd", kd1, 128'(0));
    chk("rst_lc", 128'(lc1), 128'(0));
    chk("rst_kv", 128'(kv1), 128'(0));
    chk("rst_busy", 128'(bz1), 128'(0));
    chk("rst_done", 128'(dn1), 128'(0));
    chk("rst_cnts", 128'({sc1, ec1}), 128'(0));
    rst = 1'b0;
    @(negedge clk_div);

    // reset arriving mid-HOLD of the first letter
    set_word(3, 1, 20, 0, 3);
    start = 1'b1;
    @(posedge clk_div);
    @(negedge clk_div);
    start = 1'b0;
    @(posedge clk_div);
    @(negedge clk_div);
    @(posedge clk_div);
    @(negedge clk_div);
    chk("hold_kd", kd1, 128'(1) << 33);
    chk("hold_busy", 128'(bz1), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_kd", kd1, 128'(0));
    chk("async_rst_busy", 128'(bz1), 128'(0));
    chk("async_rst_lc", 128'(lc1), 128'(0));
    @(negedge clk_div);
    rst = 1'b0;
    @(negedge clk_div);

    // "cat" at default timing
    set_word(3, 1, 20, 0, 3);
    model(2, 3);
    start = 1'b1;
    run(35, -1, -1);
    finish_checks("cat");
    chk("cat_pulses", 128'(pulses), 128'(8));

    // "z" with mistype: a, BACK, z, SPACE
    set_word(26, 0, 0, 0, 1);
    inject_err = 1'b1;
    model(2, 3);
    start = 1'b1;
    run(35, -1, -1);
    finish_checks("z_inj");
    chk("z_inj_pulses", 128'(pulses), 128'(8));
    inject_err = 1'b0;

    // empty word
    set_word(3, 1, 20, 0, 0);
    model(2, 3);
    start = 1'b1;
    run(6, -1, -1);
    finish_checks("empty");
    chk("empty_pulses", 128'(pulses), 128'(0));

    // terminator code 0 at index 1 ends the word early
    set_word(3, 0, 20, 1, 5);
    model(2, 3);
    start = 1'b1;
    run(22, -1, -1);
    finish_checks("early");

    // oversize wordnum clamps; only 4 letters exist so code 0 ends it
    set_word(2, 5, 4, 19, 31);
    model(2, 3);
    start = 1'b1;
    run(45, -1, -1);
    finish_checks("clamp");

    // abort during HOLD of letter 2; restart pulsed while busy at edge 2
    set_word(3, 1, 20, 0, 3);
    model(2, 3);
    start = 1'b1;
    run(20, 9, 2);
    chk("abort_no_done", 128'(got_done), 128'(-1));
    chk("abort_left", 128'(q.size()), 128'(5));
    chk("abort_sent_hold", 128'(sc1), 128'(1));
    chk("abort_err_hold", 128'(ec1), 128'(0));
    q.delete();

    // HOLD=1 GAP=0: release and next press on consecutive edges
    sel = 1'b1;
    set_word(3, 1, 20, 0, 3);
    model(1, 0);
    start2 = 1'b1;
    run(20, -1, -1);
    finish_checks("fast");
    chk("fast_pulses", 128'(pulses), 128'(8));
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
